register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry by 32-bit RV32I integer register file with two combinational read ports and one synchronous write port.
- Sits directly upstream of the ALU: rd_data0 drives ALU operand a; rd_data1 drives operand b, or the immediate mux that feeds b.
- The write port is fed by writeback, which is ALU result or load data.
- Register x0 is hardwired to zero.

Parameters:
- N, 32, data width in bits. Only 32 is supported; it is used as a constant.
- L, 32, number of architectural registers. Only 32 is supported; the address width is $clog2(L) = 5.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset. Clears all registers.
- wr_ena  input  1  Write enable, sampled on the rising edge of clk.
- wr_addr  input  5  Destination register index.
- wr_data  input  N  Data to write.
- rd_addr0  input  5  Read port 0 index.
- rd_data0  output  N  Read port 0 data, to ALU a.
- rd_addr1  input  5  Read port 1 index.
- rd_data1  output  N  Read port 1 data, to ALU b path.

Behaviour:
- Storage: registers x1..x31 are N-bit flops with async reset and a per-register enable. x0 has no storage and always reads 32'h0000_0000.
- Reset: while rst=1, all x1..x31 are forced to 0 immediately, without waiting for clk.
  - Both read ports therefore return 0 during reset and after reset, until written.
  - A reset asserted mid-write (same cycle as wr_ena=1) wins; the write is discarded.
  - Writes resume on the first rising edge with rst=0.
- Write: on posedge clk with rst=0 and wr_ena=1, register[wr_addr] <= wr_data.
  - Exactly one register updates per edge. Decode is one-hot over 32 lines, gated by wr_ena.
  - wr_addr=0 is ignored and x0 stays 0.
  - wr_ena=0 means no register changes, regardless of wr_addr or wr_data.
- Read: rd_dataK = register[rd_addrK] combinationally (a 32:1 mux per port), with zero clock latency.
  - Both ports may address the same register simultaneously; both return the same value.
  - rd_addrK=0 returns 0.
- Write latency: a written value is visible on the read ports after the clock edge that commits it, i.e. one cycle.
- Same-cycle read/write of the same nonzero index: behaviour depends on REGFILE_BYPASS_EN (see below).
- No X propagation: all storage is reset, so no read ever returns X after the first reset.
- Timing: the read path is purely combinational, so it lies on the fetch→decode→ALU critical path. No latches are permitted.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding is enabled. If wr_ena=1, wr_addr≠0 and wr_addr==rd_addrK in the same cycle, then rd_dataK = wr_data combinationally, before the edge. This applies independently per port. The edge still commits the write.
- Undefined: rd_dataK returns the stored (old) value until the edge commits. The new value appears the following cycle.
- In both builds, x0 always reads 0, including when wr_addr=0 with wr_ena=1.

Decomposition:
- Shared package rv32i_types holds:
  - REG_ADDR_W = 5.
  - The named register index constants X0..X31, and ABI aliases (ZERO, RA, SP, …).
  - XLEN = 32.
- Sub-module register_en, instantiated 31 times: an N-bit flop with D, ENA, Q, and async active-high reset to 0.
- The write decoder is a 5:32 one-hot decoder (decoder_5_to_32), built from smaller decoders in the same style as the existing mux trees.
- Read muxes are 32:1, built as two mux16s plus a 2:1 mux.

Test Plan:
- Reset clear: write 32'hDEAD_BEEF to x5, then assert rst asynchronously mid-cycle. Required: rd_data0 with rd_addr0=5 reads 0 before the next clk edge.
- x0 immutability: wr_ena=1, wr_addr=0, wr_data=32'hFFFF_FFFF. Required: rd_addr0=0 and rd_addr1=0 both return 0, in both builds.
- Write/read sweep: for i=1..31, write i*32'h0101_0101 to x[i]. Then read all pairs (i, 32-i). Required: each port returns its register's exact value, and port 1 is independent of port 0.
- Enable gating: write 32'h1234_5678 to x7, then a cycle with wr_ena=0, wr_addr=7, wr_data=32'hAAAA_AAAA. Required: x7 still reads 32'h1234_5678.
- Same-cycle read/write: x9=32'h1 stored. Present wr_ena=1, wr_addr=9, wr_data=32'h2 with rd_addr0=rd_addr1=9. Required before the edge: 32'h2 with REGFILE_BYPASS_EN, 32'h1 without. Required after the edge: 32'h2 in both builds.
- Reset during write: rst rises in the same cycle as wr_ena=1, wr_addr=3, wr_data=32'h55. Required: after rst falls, x3 reads 0. The next write of 32'h55 to x3 then succeeds.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I definitions: data width, register index width, and the
// architectural register names with their ABI aliases.
package rv32i_types;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [REG_ADDR_W-1:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } reg_idx_e;

  localparam reg_idx_e ZERO = X0;
  localparam reg_idx_e RA   = X1;
  localparam reg_idx_e SP   = X2;
  localparam reg_idx_e GP   = X3;
  localparam reg_idx_e TP   = X4;
  localparam reg_idx_e T0   = X5;
  localparam reg_idx_e T1   = X6;
  localparam reg_idx_e T2   = X7;
  localparam reg_idx_e S0   = X8;
  localparam reg_idx_e FP   = X8;
  localparam reg_idx_e S1   = X9;
  localparam reg_idx_e A0   = X10;
  localparam reg_idx_e A1   = X11;
  localparam reg_idx_e A2   = X12;
  localparam reg_idx_e A3   = X13;
  localparam reg_idx_e A4   = X14;
  localparam reg_idx_e A5   = X15;
  localparam reg_idx_e A6   = X16;
  localparam reg_idx_e A7   = X17;
  localparam reg_idx_e S2   = X18;
  localparam reg_idx_e S3   = X19;
  localparam reg_idx_e S4   = X20;
  localparam reg_idx_e S5   = X21;
  localparam reg_idx_e S6   = X22;
  localparam reg_idx_e S7   = X23;
  localparam reg_idx_e S8   = X24;
  localparam reg_idx_e S9   = X25;
  localparam reg_idx_e S10  = X26;
  localparam reg_idx_e S11  = X27;
  localparam reg_idx_e T3   = X28;
  localparam reg_idx_e T4   = X29;
  localparam reg_idx_e T5   = X30;
  localparam reg_idx_e T6   = X31;

endpackage

// File: rtl/register_file_cells.sv
// Building blocks for the register file: enabled flop, one-hot write
// decoder tree and the 32:1 read mux tree.
module register_en
  import rv32i_types::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (ena) q <= d;
  end
endmodule

module decoder_2_to_4 (
  input  logic       ena,
  input  logic [1:0] sel,
  output logic [3:0] out
);
  always_comb begin
    out = '0;
    if (ena) out[sel] = 1'b1;
  end
endmodule

module decoder_3_to_8 (
  input  logic       ena,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  always_comb begin
    out = '0;
    if (ena) out[sel] = 1'b1;
  end
endmodule

module decoder_5_to_32 (
  input  logic        ena,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  logic [3:0] hi;
  logic [7:0] lo;

  decoder_2_to_4 u_hi (.ena(ena),  .sel(sel[4:3]), .out(hi));
  decoder_3_to_8 u_lo (.ena(1'b1), .sel(sel[2:0]), .out(lo));

  // Line k = hi group (k/8) AND low line (k%8); enable lives only in the hi stage.
  always_comb begin
    for (int unsigned k = 0; k < 32; k++) out[k] = hi[k/8] & lo[k%8];
  end
endmodule

module mux16
  import rv32i_types::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [15:0][W-1:0] in,
  input  logic [3:0]         sel,
  output logic [W-1:0]       out
);
  assign out = in[sel];
endmodule

module mux_32_to_1
  import rv32i_types::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [31:0][W-1:0] in,
  input  logic [4:0]         sel,
  output logic [W-1:0]       out
);
  logic [W-1:0] lo_half;
  logic [W-1:0] hi_half;

  mux16 #(.W(W)) u_lo (.in(in[15:0]),  .sel(sel[3:0]), .out(lo_half));
  mux16 #(.W(W)) u_hi (.in(in[31:16]), .sel(sel[3:0]), .out(hi_half));

  assign out = sel[4] ? hi_half : lo_half;
endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 2 combinational read ports, 1 write port, x0 = 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file
  import rv32i_types::*;
#(
  parameter int unsigned N = XLEN,
  parameter int unsigned L = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_ena,
  input  logic [$clog2(L)-1:0] wr_addr,
  input  logic [N-1:0]         wr_data,
  input  logic [$clog2(L)-1:0] rd_addr0,
  output logic [N-1:0]         rd_data0,
  input  logic [$clog2(L)-1:0] rd_addr1,
  output logic [N-1:0]         rd_data1
);
  logic [31:0]        wr_sel;
  logic [31:0][N-1:0] regs;
  logic [N-1:0]       mux_data0;
  logic [N-1:0]       mux_data1;
  logic               unused_wr_sel0;

  decoder_5_to_32 u_dec (.ena(wr_ena), .sel(wr_addr), .out(wr_sel));

  // x0 has no flop; its decode line is deliberately left dangling.
  assign unused_wr_sel0 = wr_sel[0];
  assign regs[0]        = '0;

  for (genvar i = 1; i < 32; i++) begin : g_reg
    register_en #(.W(N)) u_reg (
      .clk(clk),
      .rst(rst),
      .ena(wr_sel[i]),
      .d  (wr_data),
      .q  (regs[i])
    );
  end

  mux_32_to_1 #(.W(N)) u_rd0 (.in(regs), .sel(rd_addr0), .out(mux_data0));
  mux_32_to_1 #(.W(N)) u_rd1 (.in(regs), .sel(rd_addr1), .out(mux_data1));

`ifdef REGFILE_BYPASS_EN
  logic fwd0;
  logic fwd1;

  assign fwd0     = wr_ena && (wr_addr != X0) && (wr_addr == rd_addr0);
  assign fwd1     = wr_ena && (wr_addr != X0) && (wr_addr == rd_addr1);
  assign rd_data0 = fwd0 ? wr_data : mux_data0;
  assign rd_data1 = fwd1 ? wr_data : mux_data1;
`else
  assign rd_data0 = mux_data0;
  assign rd_data1 = mux_data1;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file (either bypass build).
module tb_register_file;
  logic        clk;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [31:0] rd_data0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[31];

  register_file #(.N(32), .L(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_ena  (wr_ena),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr0(rd_addr0),
    .rd_data0(rd_data0),
    .rd_addr1(rd_addr1),
    .rd_data1(rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
  endtask

  task automatic read(input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    rd_addr0 = a0;
    rd_addr1 = a1;
    #1;
  endtask

  initial begin
    logic [31:0] pre_exp;

    for (int i = 1; i < 32; i++) begin
      logic [31:0] k0;
      logic [31:0] k1;
      k0 = i;
      k1 = 32 - i;
      vecs[i-1].a0 = k0[4:0];
      vecs[i-1].a1 = k1[4:0];
      vecs[i-1].e0 = k0 * 32'h0101_0101;
      vecs[i-1].e1 = k1 * 32'h0101_0101;
    end

    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = 5'd5; rd_addr1 = 5'd31;
    #1;
    check("reset_x5_p0", rd_data0, 32'h0);
    check("reset_x31_p1", rd_data1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset clears a stored value before any clock edge.
    write(5'd5, 32'hDEAD_BEEF);
    rd_addr0 = 5'd5;
    #1;
    check("x5_written", rd_data0, 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_x5", rd_data0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    write(5'd0, 32'hFFFF_FFFF);
    read(5'd0, 5'd0);
    check("x0_p0", rd_data0, 32'h0);
    check("x0_p1", rd_data1, 32'h0);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    #1;
    check("x0_p0_during_write", rd_data0, 32'h0);
    check("x0_p1_during_write", rd_data1, 32'h0);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;

    for (int i = 1; i < 32; i++) begin
      logic [31:0] k;
      k = i;
      write(k[4:0], k * 32'h0101_0101);
    end
    for (int i = 0; i < 31; i++) begin
      read(vecs[i].a0, vecs[i].a1);
      check($sformatf("sweep_p0_x%0d", vecs[i].a0), rd_data0, vecs[i].e0);
      check($sformatf("sweep_p1_x%0d", vecs[i].a1), rd_data1, vecs[i].e1);
    end

    write(5'd7, 32'h1234_5678);
    @(negedge clk);
    wr_ena = 1'b0; wr_addr = 5'd7; wr_data = 32'hAAAA_AAAA;
    @(posedge clk);
    read(5'd7, 5'd8);
    check("ena_gate_x7", rd_data0, 32'h1234_5678);
    check("ena_gate_x8", rd_data1, 32'h0808_0808);

    write(5'd9, 32'h1);
`ifdef REGFILE_BYPASS_EN
    pre_exp = 32'h2;
`else
    pre_exp = 32'h1;
`endif
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h2;
    rd_addr0 = 5'd9; rd_addr1 = 5'd9;
    #1;
    check("rw_same_pre_p0", rd_data0, pre_exp);
    check("rw_same_pre_p1", rd_data1, pre_exp);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    check("rw_same_post_p0", rd_data0, 32'h2);
    check("rw_same_post_p1", rd_data1, 32'h2);

    // Reset asserted in the same cycle as a write must discard that write.
    @(negedge clk);
    rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr_ena = 1'b0;
    read(5'd3, 5'd9);
    check("rst_write_x3", rd_data0, 32'h0);
    check("rst_clears_x9", rd_data1, 32'h0);
    write(5'd3, 32'h55);
    read(5'd3, 5'd4);
    check("after_rst_x3", rd_data0, 32'h55);
    check("after_rst_x4", rd_data1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
